// File: rtl/dense_pkg.sv
// Shared types and encodings for the dense-layer MAC block.
package dense_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_IN = 3'd1,
        MAC     = 3'd2,
        STORE   = 3'd3,
        FINISH  = 3'd4
    } state_e;

    // Activation selection
    localparam int unsigned ACT_NONE       = 0;
    localparam int unsigned ACT_RELU       = 1;
    localparam int unsigned ACT_RELU_CLAMP = 2;

endpackage

// File: rtl/dense_sat_act.sv
// Saturating accumulate and output activation, purely combinational.
module dense_sat_act
    import dense_pkg::*;
#(
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned P_W      = 17,
    parameter int unsigned ACT_MODE = 0,
    parameter int unsigned ACT_MAX  = 6
) (
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic signed [P_W-1:0]   addend,
    input  logic signed [ACC_W-1:0] act_in,
    output logic signed [ACC_W-1:0] sum_c,
    output logic signed [ACC_W-1:0] act_c
);

    // One guard bit above the wider operand makes the raw sum exact
    localparam int unsigned SUM_W = ((ACC_W > P_W) ? ACC_W : P_W) + 1;
    localparam int unsigned PAD_A = SUM_W - ACC_W;
    localparam int unsigned PAD_P = SUM_W - P_W;
    localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_V = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACT_MAX_V = ACC_W'(ACT_MAX);

    logic signed [SUM_W-1:0] wide;

    // Exact sum, then clamp into the accumulator range
    always_comb begin
        wide = {{PAD_A{acc_in[ACC_W-1]}}, acc_in} + {{PAD_P{addend[P_W-1]}}, addend};
        if (wide > MAX_V) begin
            sum_c = MAX_V[ACC_W-1:0];
        end else if (wide < MIN_V) begin
            sum_c = MIN_V[ACC_W-1:0];
        end else begin
            sum_c = wide[ACC_W-1:0];
        end
    end

    // Activation applied to a finished neuron value
    always_comb begin
        act_c = act_in;
        if (ACT_MODE != ACT_NONE && act_in[ACC_W-1]) begin
            act_c = '0;
        end else if (ACT_MODE == ACT_RELU_CLAMP && act_in > ACT_MAX_V) begin
            act_c = ACT_MAX_V;
        end
    end

endmodule

// File: rtl/dense_layer_param_mac.sv
// Sequential dense layer: buffers the input vector, then one MAC per cycle per neuron.
module dense_layer_param_mac
    import dense_pkg::*;
#(
    parameter int unsigned IN_DIM    = 128,
    parameter int unsigned OUT_DIM   = 9,
    parameter int unsigned IN_W      = 8,
    parameter int unsigned IN_SIGNED = 0,
    parameter int unsigned W_W       = 8,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned ACT_MODE  = 0,
    parameter int unsigned ACT_MAX   = 6
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(IN_DIM)-1:0]          in_addr,
    input  logic [IN_W-1:0]                    in_data,
    output logic [$clog2(IN_DIM*OUT_DIM)-1:0]  w_addr,
    input  logic [W_W-1:0]                     w_data,
    output logic [$clog2(OUT_DIM)-1:0]         b_addr,
    input  logic [W_W-1:0]                     b_data,
    input  logic [$clog2(OUT_DIM)-1:0]         read_addr,
    output logic [ACC_W-1:0]                   read_data,
    output logic [$clog2(OUT_DIM)-1:0]         argmax_idx
);

    localparam int unsigned IA_W = $clog2(IN_DIM);
    localparam int unsigned WA_W = $clog2(IN_DIM*OUT_DIM);
    localparam int unsigned NW   = $clog2(OUT_DIM);
    localparam int unsigned NW1  = NW + 1;
    localparam int unsigned CW   = $clog2(IN_DIM + 1);
    localparam int unsigned P_W  = IN_W + 1 + W_W;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NW-1:0]           n_q, n_d;
    logic                    busy_d, done_d;
    logic [IA_W-1:0]         in_addr_d;
    logic [WA_W-1:0]         w_addr_d;
    logic [NW-1:0]           b_addr_d;
    logic [IN_W-1:0]         x_mem [IN_DIM];
    logic signed [ACC_W-1:0] out_mem [OUT_DIM];
    logic signed [ACC_W-1:0] acc_q, best_q, acc_in, sum_c, act_c;
    logic [IN_W-1:0]         x_sel;
    logic [IN_W:0]           x_ext;
    logic signed [P_W-1:0]   prod;

    // State, cycle-in-state and neuron registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
        end
    end

    // Next state; cnt restarts at 0 on every state change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                n_d = '0;
                if (start) state_d = LOAD_IN;
            end
            LOAD_IN: if (cnt_q == CW'(IN_DIM)) state_d = MAC;
            MAC:     if (cnt_q == CW'(IN_DIM)) state_d = STORE;
            STORE: begin
                if (n_q == NW'(OUT_DIM - 1)) begin
                    state_d = FINISH;
                end else begin
                    state_d = MAC;
                    n_d     = n_q + NW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Next values of the registered outputs; addresses lead data by one cycle
    always_comb begin
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == FINISH);
        in_addr_d = in_addr;
        w_addr_d  = w_addr;
        b_addr_d  = b_addr;
        if (state_d == LOAD_IN && cnt_d < CW'(IN_DIM)) in_addr_d = IA_W'(cnt_d);
        if (state_d == MAC && cnt_d < CW'(IN_DIM)) w_addr_d = WA_W'(32'(n_d) * IN_DIM + 32'(cnt_d));
        if (state_d == MAC && cnt_d == '0) b_addr_d = n_d;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            in_addr <= '0;
            w_addr  <= '0;
            b_addr  <= '0;
        end else begin
            busy    <= busy_d;
            done    <= done_d;
            in_addr <= in_addr_d;
            w_addr  <= w_addr_d;
            b_addr  <= b_addr_d;
        end
    end

    // Input vector capture, one cycle behind in_addr
    always_ff @(posedge clk) begin
        if (state_q == LOAD_IN && cnt_q != '0) x_mem[IA_W'(cnt_q - CW'(1))] <= in_data;
    end

    // Product for element cnt-1; bias is folded into the first add
    always_comb begin
        x_sel  = x_mem[IA_W'(cnt_q - CW'(1))];
        x_ext  = (IN_SIGNED != 0) ? {x_sel[IN_W-1], x_sel} : {1'b0, x_sel};
        prod   = $signed({{W_W{x_ext[IN_W]}}, x_ext}) * $signed({{(IN_W+1){w_data[W_W-1]}}, w_data});
        acc_in = (cnt_q == CW'(1)) ? ACC_W'($signed(b_data)) : acc_q;
    end

    dense_sat_act #(
        .ACC_W    (ACC_W),
        .P_W      (P_W),
        .ACT_MODE (ACT_MODE),
        .ACT_MAX  (ACT_MAX)
    ) u_sat_act (
        .acc_in (acc_in),
        .addend (prod),
        .act_in (acc_q),
        .sum_c  (sum_c),
        .act_c  (act_c)
    );

    // Accumulator, output RAM and running argmax (ties keep the lower index)
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            best_q     <= '0;
            argmax_idx <= '0;
            for (int i = 0; i < int'(OUT_DIM); i++) out_mem[i] <= '0;
        end else begin
            if (state_q == MAC && cnt_q != '0) acc_q <= sum_c;
            if (state_q == STORE) begin
                out_mem[n_q] <= act_c;
                if (n_q == '0 || act_c > best_q) begin
                    best_q     <= act_c;
                    argmax_idx <= n_q;
                end
            end
        end
    end

    // Combinational read port, zero beyond the last neuron
    always_comb begin
        read_data = '0;
        if ({1'b0, read_addr} < NW1'(OUT_DIM)) read_data = out_mem[read_addr];
    end

endmodule

// File: tb/tb_dense_layer_param_mac.sv
// Four parameterisations of dense_layer_param_mac driven from shared memories.
module tb_dense_layer_param_mac;

    localparam int NCFG    = 4;
    localparam int IN_DIM  = 4;
    localparam int OUT_DIM = 3;
    localparam int ACT_MAX = 6;
    localparam int CFG_IN_W [NCFG] = '{4, 4, 4, 8};
    localparam int CFG_SGN  [NCFG] = '{0, 0, 0, 1};
    localparam int CFG_ACC  [NCFG] = '{32, 32, 32, 8};
    localparam int CFG_ACT  [NCFG] = '{0, 2, 1, 0};

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] read_addr;

    int   x_mem [4];
    int   w_mem [16];
    int   b_mem [4];

    int   rd_data [NCFG];
    int   amax_v  [NCFG];
    logic busy_v  [NCFG];
    logic done_v  [NCFG];

    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int unsigned GW = CFG_IN_W[g];
        localparam int unsigned GA = CFG_ACC[g];
        logic [1:0]    in_addr;
        logic [GW-1:0] in_data;
        logic [3:0]    w_addr;
        logic [7:0]    w_data;
        logic [1:0]    b_addr;
        logic [7:0]    b_data;
        logic [GA-1:0] rdata;
        logic [1:0]    amax;
        logic          busy, done;

        dense_layer_param_mac #(
            .IN_DIM    (IN_DIM),
            .OUT_DIM   (OUT_DIM),
            .IN_W      (GW),
            .IN_SIGNED (CFG_SGN[g]),
            .W_W       (8),
            .ACC_W     (GA),
            .ACT_MODE  (CFG_ACT[g]),
            .ACT_MAX   (ACT_MAX)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .busy       (busy),
            .done       (done),
            .in_addr    (in_addr),
            .in_data    (in_data),
            .w_addr     (w_addr),
            .w_data     (w_data),
            .b_addr     (b_addr),
            .b_data     (b_data),
            .read_addr  (read_addr),
            .read_data  (rdata),
            .argmax_idx (amax)
        );

        // Synchronous-read memories: data one cycle after address
        always @(posedge clk) begin
            in_data <= GW'(x_mem[in_addr]);
            w_data  <= 8'(w_mem[w_addr]);
            b_data  <= 8'(b_mem[b_addr]);
        end

        assign rd_data[g] = int'($signed(rdata));
        assign amax_v[g]  = int'(amax);
        assign busy_v[g]  = busy;
        assign done_v[g]  = done;
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: integer dot product with per-step clamping, then activation
    function automatic longint model_out(input int c, input int n);
        longint acc, xv, hi, lo;
        hi  = (longint'(1) << (CFG_ACC[c] - 1)) - 1;
        lo  = -hi - 1;
        acc = b_mem[n];
        for (int i = 0; i < IN_DIM; i++) begin
            xv = longint'(x_mem[i]) & ((longint'(1) << CFG_IN_W[c]) - 1);
            if (CFG_SGN[c] != 0 && xv >= (longint'(1) << (CFG_IN_W[c] - 1)))
                xv -= longint'(1) << CFG_IN_W[c];
            acc += xv * w_mem[n*IN_DIM + i];
            if (acc > hi) acc = hi;
            if (acc < lo) acc = lo;
        end
        if (CFG_ACT[c] != 0 && acc < 0) acc = 0;
        if (CFG_ACT[c] == 2 && acc > ACT_MAX) acc = ACT_MAX;
        return acc;
    endfunction

    function automatic int model_argmax(input int c);
        longint best;
        int     idx;
        best = model_out(c, 0);
        idx  = 0;
        for (int n = 1; n < OUT_DIM; n++) begin
            if (model_out(c, n) > best) begin
                best = model_out(c, n);
                idx  = n;
            end
        end
        return idx;
    endfunction

    task automatic check_results(input string tag);
        for (int c = 0; c < NCFG; c++) begin
            for (int n = 0; n < OUT_DIM; n++) begin
                read_addr = 2'(n);
                #1;
                check_eq($sformatf("%s_c%0d_out%0d", tag, c, n), rd_data[c], model_out(c, n));
            end
            read_addr = 2'd3;
            #1;
            check_eq($sformatf("%s_c%0d_oob", tag, c), rd_data[c], 0);
            check_eq($sformatf("%s_c%0d_argmax", tag, c), amax_v[c], model_argmax(c));
        end
    endtask

    task automatic check_lit(input string tag, input int c, input int n, input int exp);
        read_addr = 2'(n);
        #1;
        check_eq(tag, rd_data[c], exp);
    endtask

    // One inference; stray_start also pulses start mid-MAC and on the done cycle
    task automatic run_inf(input string tag, input bit stray_start);
        int cyc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_eq({tag, "_busy_first"}, busy_v[0], 1);
        cyc = 1;
        while (cyc < 60 && done_v[0] !== 1'b1) begin
            start = (stray_start && cyc == 8) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check_eq({tag, "_done_latency"}, cyc, 24);
        check_eq({tag, "_busy_at_done"}, busy_v[0], 1);
        for (int c = 1; c < NCFG; c++) check_eq($sformatf("%s_c%0d_done_sync", tag, c), done_v[c], 1);
        if (stray_start) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_eq({tag, "_done_pulse"}, done_v[0], 0);
        check_eq({tag, "_busy_after"}, busy_v[0], 0);
        @(posedge clk);
        #1;
        check_eq({tag, "_still_idle"}, busy_v[0], 0);
    endtask

    task automatic set_base();
        for (int i = 0; i < 16; i++) w_mem[i] = 0;
        x_mem = '{1, 2, 3, 4};
        w_mem[0] = 1;  w_mem[1] = 1; w_mem[2]  = 1; w_mem[3]  = 1;
        w_mem[4] = -1;
        w_mem[8] = 2;  w_mem[11] = 1;
        b_mem = '{0, 5, -3, 0};
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        read_addr = 2'd0;
        for (int i = 0; i < 16; i++) w_mem[i] = 0;
        x_mem = '{0, 0, 0, 0};
        b_mem = '{0, 0, 0, 0};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check_eq("rst_busy", busy_v[0], 0);
        check_eq("rst_done", done_v[0], 0);
        check_eq("rst_argmax", amax_v[0], 0);
        for (int n = 0; n < 4; n++) check_lit($sformatf("rst_out%0d", n), 0, n, 0);

        // Reference vectors
        set_base();
        run_inf("base", 1'b0);
        check_results("base");
        check_lit("base_lit_o0", 0, 0, 10);
        check_lit("base_lit_o1", 0, 1, 4);
        check_lit("base_lit_o2", 0, 2, 3);
        check_lit("clamp6_lit_o0", 1, 0, 6);

        // Negative pre-activation on neuron 1
        b_mem[1] = -10;
        run_inf("neg", 1'b0);
        check_results("neg");
        check_lit("relu_lit_o1", 2, 1, 0);

        // Tied maxima {7,7,2} with stray starts
        for (int i = 0; i < 16; i++) w_mem[i] = 0;
        w_mem[0] = 1; w_mem[2] = 2; w_mem[7] = 1;
        b_mem = '{0, 3, 2, 0};
        run_inf("tie", 1'b1);
        check_results("tie");
        check_eq("tie_lit_argmax", amax_v[0], 0);

        // Saturation: large positive products
        x_mem = '{127, 127, 127, 127};
        for (int i = 0; i < 16; i++) w_mem[i] = 127;
        b_mem = '{0, 0, 0, 0};
        run_inf("sat", 1'b0);
        check_results("sat");
        check_lit("sat_lit_o2", 3, 2, 127);

        // Reset mid-MAC aborts; start in first post-reset cycle is accepted
        set_base();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < NCFG; c++) begin
            check_eq($sformatf("abort_c%0d_busy", c), busy_v[c], 0);
            check_eq($sformatf("abort_c%0d_done", c), done_v[c], 0);
            for (int n = 0; n < 4; n++) check_lit($sformatf("abort_c%0d_out%0d", c, n), c, n, 0);
        end
        reset = 1'b0;
        run_inf("post_rst", 1'b0);
        check_results("post_rst");
        check_lit("post_rst_lit_o0", 0, 0, 10);

        // Signed inputs
        x_mem = '{-1, -1, -1, -1};
        for (int i = 0; i < 16; i++) w_mem[i] = (i < 4) ? 1 : int'($urandom_range(0, 20)) - 10;
        b_mem = '{0, 1, -1, 0};
        run_inf("signed", 1'b0);
        check_results("signed");
        check_lit("signed_lit_o0", 3, 0, -4);

        // Random vectors
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < IN_DIM; i++) x_mem[i] = int'($urandom_range(0, 255));
            for (int i = 0; i < IN_DIM*OUT_DIM; i++) w_mem[i] = int'($urandom_range(0, 255)) - 128;
            for (int n = 0; n < OUT_DIM; n++) b_mem[n] = int'($urandom_range(0, 255)) - 128;
            run_inf($sformatf("rnd%0d", r), r[0]);
            check_results($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
